// File: rtl/imm_enc_pkg.sv
// Shared types and helpers for the immediate encoder: format codes, stage payloads,
// the immediate packer and the representability check.
package imm_enc_pkg;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  typedef struct packed {
    imm_src_e    src;
    logic [31:0] imm;
    logic [31:0] base;
    logic        err;
  } s1_word_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } s2_word_t;

  function automatic logic [31:0] pack_imm(input imm_src_e src, input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] word;
    case (src)
      IMM_I:   word = {imm[11:0], base[19:0]};
      IMM_S:   word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      IMM_B:   word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      default: word = base;
    endcase
    return word;
  endfunction

  // The upper bits must be pure sign extension; B offsets must also be even.
  function automatic logic imm_fits(input imm_src_e src, input logic [31:0] imm);
    logic fits;
    case (src)
      IMM_I, IMM_S: fits = (&imm[31:11]) | ~(|imm[31:11]);
      IMM_B:        fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      default:      fits = 1'b1;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/imm_pipe_stage.sv
// Valid/ready register slice; accepts a new word whenever it is empty or draining
// in the same cycle, so a chain of slices sustains one word per cycle.
module imm_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         load_s;

  assign in_ready  = !valid_r || out_ready;
  assign load_s    = in_valid && in_ready && !flush;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // occupancy flag; flush wins over any handshake in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (in_ready) begin
      valid_r <= in_valid;
    end
  end

  // payload register; holds while stalled so the outputs stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (load_s) begin
      data_r <= in_data;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Packs a sign-extended immediate into the instruction bit positions of its format,
// through a two-stage valid/ready pipeline with address and error counters.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        ImmSrc,
  input  logic [31:0]       ImmExt,
  input  logic [31:0]       Base,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] WrAddr,
  output logic              RangeErr,
  output logic [ERR_W-1:0]  ErrCnt
);

  s1_word_t          s1_in_s;
  s1_word_t          s1_out_s;
  s2_word_t          s2_in_s;
  s2_word_t          s2_out_s;
  logic              s1_valid_s;
  logic              s2_ready_s;
  logic              out_fire_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ERR_W-1:0]  err_cnt_r;

  assign s1_in_s.src  = imm_src_e'(ImmSrc);
  assign s1_in_s.imm  = ImmExt;
  assign s1_in_s.base = Base;
  assign s1_in_s.err  = ~imm_fits(imm_src_e'(ImmSrc), ImmExt);

  imm_pipe_stage #(.W($bits(s1_word_t))) u_s1 (
    .clk       (CLK),
    .rst_n     (RST),
    .flush     (Flush),
    .in_valid  (InValid),
    .in_ready  (InReady),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_out_s)
  );

  assign s2_in_s.instr = pack_imm(s1_out_s.src, s1_out_s.imm, s1_out_s.base);
  assign s2_in_s.err   = s1_out_s.err;

  imm_pipe_stage #(.W($bits(s2_word_t))) u_s2 (
    .clk       (CLK),
    .rst_n     (RST),
    .flush     (Flush),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (OutValid),
    .out_ready (OutReady),
    .out_data  (s2_out_s)
  );

  assign Instr    = s2_out_s.instr;
  assign RangeErr = s2_out_s.err;
  assign WrAddr   = wr_addr_r;
  assign ErrCnt   = err_cnt_r;

  // a handshake coinciding with Flush is discarded, so it must not advance the counters
  assign out_fire_s = OutValid && OutReady && !Flush;

  // byte address of the word on Instr; wraps silently
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_addr_r <= '0;
    end else if (out_fire_s) begin
      wr_addr_r <= wr_addr_r + ADDR_W'(4);
    end
  end

  // saturating count of delivered out-of-range words
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_r <= '0;
    end else if (out_fire_s && RangeErr && (err_cnt_r != {ERR_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed format/boundary cases plus randomized traffic
// scored against an arithmetic model with a decode round trip.
module tb_imm_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Flush, InValid, InReady, OutValid, OutReady, RangeErr;
  logic [1:0]  ImmSrc;
  logic [31:0] ImmExt, Base, Instr, WrAddr;
  logic [7:0]  ErrCnt;

  imm_encoder #(.ADDR_W(32), .ERR_W(8)) dut (
    .CLK(CLK), .RST(RST), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .ImmExt(ImmExt), .Base(Base), .OutValid(OutValid),
    .OutReady(OutReady), .Instr(Instr), .WrAddr(WrAddr), .RangeErr(RangeErr),
    .ErrCnt(ErrCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
  } word_t;

  int          n_vec = 0;
  int          n_mis = 0;
  word_t       q[$];
  word_t       head;
  logic [31:0] m_addr = 32'd0;
  logic [7:0]  m_err = 8'd0;
  bit          was_stall = 1'b0;
  logic [31:0] hold_instr, hold_addr;
  logic        hold_err;
  bit          force_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // expected instruction from field masks and shifts
  function automatic logic [31:0] model_instr(input logic [1:0] s, input logic [31:0] imm,
                                              input logic [31:0] base);
    case (s)
      2'd0: return (base & 32'h000F_FFFF) | (imm << 20);
      2'd1: return (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      2'd2: return (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                 | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                 | (((imm >> 11) & 32'h1) << 7);
      default: return base;
    endcase
  endfunction

  // expected range error from the signed value range of each format
  function automatic logic model_err(input logic [1:0] s, input logic [31:0] imm);
    int v;
    v = imm;
    case (s)
      2'd0, 2'd1: return !(v >= -2048 && v <= 2047);
      2'd2:       return !(v >= -4096 && v <= 4094 && imm[0] == 1'b0);
      default:    return 1'b0;
    endcase
  endfunction

  // sign-extension decoder, used for the round trip
  function automatic logic [31:0] decode(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return w;
    endcase
  endfunction

  // scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      q.delete();
      m_addr    = 32'd0;
      m_err     = 8'd0;
      was_stall = 1'b0;
    end else if (!CLK) begin
      check_eq("inready", 32'(InReady), 32'((q.size() < 2) || OutReady));
      check_eq("errcnt", 32'(ErrCnt), 32'(m_err));
      if (was_stall) begin
        check_eq("stall_valid", 32'(OutValid), 32'd1);
        check_eq("stall_instr", Instr, hold_instr);
        check_eq("stall_addr", WrAddr, hold_addr);
        check_eq("stall_err", 32'(RangeErr), 32'(hold_err));
      end
      if (Flush) begin
        q.delete();
      end else begin
        if (OutValid && OutReady) begin
          if (q.size() == 0) begin
            check_eq("spurious_out", 32'd1, 32'd0);
          end else begin
            head = q.pop_front();
            check_eq("instr", Instr, model_instr(head.src, head.imm, head.base));
            check_eq("rangeerr", 32'(RangeErr), 32'(model_err(head.src, head.imm)));
            check_eq("wraddr", WrAddr, m_addr);
            if (!model_err(head.src, head.imm) && head.src != 2'd3)
              check_eq("roundtrip", decode(Instr, head.src), head.imm);
            m_addr = m_addr + 32'd4;
            if (model_err(head.src, head.imm) && m_err != 8'hFF) m_err = m_err + 8'd1;
          end
        end
        if (InValid && InReady) q.push_back('{src: ImmSrc, imm: ImmExt, base: Base});
      end
      was_stall  = OutValid && !OutReady && !Flush;
      hold_instr = Instr;
      hold_addr  = WrAddr;
      hold_err   = RangeErr;
    end
  end

  task automatic rand_word();
    if (force_err) begin
      ImmSrc = 2'd0;
      ImmExt = 32'h0000_1000 + $urandom_range(0, 1000);
    end else begin
      ImmSrc = 2'($urandom_range(0, 3));
      ImmExt = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 8191)) - 32'd4096);
    end
    Base = $urandom;
  endtask

  // one word into an empty pipe with OutReady high; entered and left at posedge+1
  task automatic directed(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] base,
                          input logic [31:0] exp_i, input logic exp_e, input logic [31:0] exp_a,
                          input string tag);
    int lat = 0;
    ImmSrc = s; ImmExt = imm; Base = base; InValid = 1'b1;
    @(negedge CLK);
    check_eq({tag, "_rdy"}, 32'(InReady), 32'd1);
    @(posedge CLK); #1;
    InValid = 1'b0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!OutValid && lat < 10);
    check_eq({tag, "_lat"}, 32'(lat), 32'd2);
    check_eq({tag, "_instr"}, Instr, exp_i);
    check_eq({tag, "_err"}, 32'(RangeErr), 32'(exp_e));
    check_eq({tag, "_addr"}, WrAddr, exp_a);
    @(posedge CLK); #1;
  endtask

  // n accepted words; rnd adds idle gaps, random backpressure and flushes,
  // otherwise input is back-to-back with OutReady low for cycles 3..5
  task automatic stream(input int n, input bit rnd);
    int sent = 0;
    int cyc = 0;
    bit took;
    InValid = 1'b0;
    while (sent < n && cyc < 4000) begin
      if (!InValid) begin
        InValid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (InValid) rand_word();
      end
      OutReady = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc < 6);
      Flush    = rnd && ($urandom_range(0, 39) == 0);
      @(negedge CLK);
      took = InValid && InReady && !Flush;
      @(posedge CLK); #1;
      cyc++;
      if (took) begin
        sent++;
        InValid = 1'b0;
      end
    end
    InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    check_eq("stream_timeout", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    int g = 0;
    OutReady = 1'b1; InValid = 1'b0; Flush = 1'b0;
    while (q.size() != 0 && g < 50) begin
      @(posedge CLK); #1;
      g++;
    end
    check_eq("drain", 32'(q.size()), 32'd0);
  endtask

  logic [7:0]  e_before;
  logic [31:0] a_before;

  initial begin
    Flush = 1'b0; InValid = 1'b0; ImmSrc = 2'd0; ImmExt = 32'd0; Base = 32'd0; OutReady = 1'b0;
    #12;
    check_eq("rst_outvalid", 32'(OutValid), 32'd0);
    check_eq("rst_instr", Instr, 32'd0);
    check_eq("rst_wraddr", WrAddr, 32'd0);
    check_eq("rst_rangeerr", 32'(RangeErr), 32'd0);
    check_eq("rst_errcnt", 32'(ErrCnt), 32'd0);
    @(negedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #1;
    OutReady = 1'b1;

    directed(2'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0, 32'd0,  "i_neg1");
    directed(2'd1, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0, 32'd4,  "s_8");
    directed(2'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 32'd8,  "b_m4");
    directed(2'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1, 32'd12, "b_odd");
    check_eq("errcnt_one", 32'(ErrCnt), 32'd1);
    directed(2'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 32'd16, "i_800");
    directed(2'd3, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd20, "pass");
    check_eq("errcnt_two", 32'(ErrCnt), 32'd2);

    // fresh addresses for the stalled back-to-back burst
    RST = 1'b0; #2; RST = 1'b1;
    check_eq("burst_addr0", WrAddr, 32'd0);
    @(posedge CLK); #1;
    stream(8, 1'b0);
    drain();
    check_eq("burst_addr_end", WrAddr, 32'd32);

    // flush with both stages full and a word offered in the flush cycle
    OutReady = 1'b0; InValid = 1'b1; ImmSrc = 2'd0; ImmExt = 32'h0000_3000; Base = 32'h13;
    @(posedge CLK); #1;
    ImmExt = 32'h0000_0006;
    @(posedge CLK); #1;
    InValid = 1'b0;
    @(negedge CLK);
    check_eq("fl_full_ov", 32'(OutValid), 32'd1);
    check_eq("fl_full_ir", 32'(InReady), 32'd0);
    @(posedge CLK); #1;
    e_before = ErrCnt; a_before = WrAddr;
    Flush = 1'b1; OutReady = 1'b1; InValid = 1'b1; ImmExt = 32'h0000_0007;
    @(posedge CLK); #1;
    Flush = 1'b0; InValid = 1'b0;
    @(negedge CLK);
    check_eq("fl_ov", 32'(OutValid), 32'd0);
    check_eq("fl_errcnt", 32'(ErrCnt), 32'(e_before));
    check_eq("fl_addr", WrAddr, a_before);
    repeat (3) @(negedge CLK);
    check_eq("fl_dropped", 32'(OutValid), 32'd0);
    @(posedge CLK); #1;

    // asynchronous reset in the middle of a stream of out-of-range words
    InValid = 1'b1; ImmSrc = 2'd0; ImmExt = 32'h0000_4000; Base = 32'h13;
    repeat (4) @(posedge CLK);
    #2;
    check_eq("rst_mid_ov_pre", 32'(OutValid), 32'd1);
    #1;
    RST = 1'b0;
    #1;
    check_eq("rst_mid_ov", 32'(OutValid), 32'd0);
    check_eq("rst_mid_errcnt", 32'(ErrCnt), 32'd0);
    check_eq("rst_mid_addr", WrAddr, 32'd0);
    check_eq("rst_mid_instr", Instr, 32'd0);
    InValid = 1'b0;
    @(negedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #1;

    stream(300, 1'b1);
    drain();

    force_err = 1'b1;
    stream(260, 1'b0);
    drain();
    check_eq("errcnt_sat", 32'(ErrCnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
